// File: rtl/pcm_frame_sched_if.sv
// rtl/pcm_frame_sched_if.sv - sample bus between the frame scheduler and its consumer
interface pcm_frame_sched_if #(
  parameter int NCH = 4,
  parameter int DW  = 16,
  parameter int CW  = $clog2(NCH)
);
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ch;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output out_data,
    output out_ch,
    output out_last,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_ch,
    input  out_last,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/pcm_frame_sched.sv
// rtl/pcm_frame_sched.sv - snapshots multi-channel PCM samples and serialises them onto one bus
module pcm_frame_sched #(
  parameter int NCH = 4,
  parameter int DW  = 16,
  parameter int FCW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                ce_pcm,
  input  logic [NCH*DW-1:0]   ch_data,
  input  logic                clr_ovr,
  pcm_frame_sched_if.master   bus,
  output logic                busy,
  output logic                overrun,
  output logic [FCW-1:0]      frame_cnt
);
  localparam int CW = $clog2(NCH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state;
  logic [NCH-1:0][DW-1:0] snap;
  logic [CW-1:0]          idx;
  logic [CW-1:0]          idx_nxt;
  logic [DW-1:0]          data_q;
  logic                   valid_q;
  logic                   at_last;
  logic                   xfer;
  logic                   fin;

  // Handshake decode: a beat moves on valid&ready; the frame ends on the last channel's beat.
  always_comb begin
    at_last = (idx == CW'(NCH - 1));
    idx_nxt = idx + CW'(1);
    xfer    = valid_q & bus.out_ready;
    fin     = (state == SEND) & xfer & at_last;
  end

  assign bus.out_data  = data_q;
  assign bus.out_ch    = idx;
  assign bus.out_last  = at_last;
  assign bus.out_valid = valid_q;

  // Frame FSM: capture on ce_pcm, walk channels 0..NCH-1, chain frames when ce_pcm meets the final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      snap      <= '0;
      idx       <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      // Clear first so that a simultaneous overrun set below takes priority.
      if (clr_ovr) begin
        overrun <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (ce_pcm && en) begin
            snap    <= ch_data;
            idx     <= '0;
            data_q  <= ch_data[DW-1:0];
            valid_q <= 1'b1;
            busy    <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          // A new PCM period arriving before the frame drains loses its samples.
          if (ce_pcm && !fin) begin
            overrun <= 1'b1;
          end
          if (xfer) begin
            if (!at_last) begin
              idx    <= idx_nxt;
              data_q <= snap[idx_nxt];
            end else begin
              frame_cnt <= frame_cnt + FCW'(1);
              if (ce_pcm && en) begin
                snap   <= ch_data;
                idx    <= '0;
                data_q <= ch_data[DW-1:0];
              end else begin
                valid_q <= 1'b0;
                busy    <= 1'b0;
                state   <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pcm_frame_sched.sv
// tb/tb_pcm_frame_sched.sv - scoreboard bench for pcm_frame_sched
module tb_pcm_frame_sched;
  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int FCW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    ch;
    logic          last;
  } beat_t;

  logic              clk;
  logic              rst;
  logic              en;
  logic              ce_pcm;
  logic [NCH*DW-1:0] ch_data;
  logic              clr_ovr;
  logic              busy;
  logic              overrun;
  logic [FCW-1:0]    frame_cnt;

  pcm_frame_sched_if #(.NCH(NCH), .DW(DW)) bus ();

  pcm_frame_sched #(.NCH(NCH), .DW(DW), .FCW(FCW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .ce_pcm    (ce_pcm),
    .ch_data   (ch_data),
    .clr_ovr   (clr_ovr),
    .bus       (bus),
    .busy      (busy),
    .overrun   (overrun),
    .frame_cnt (frame_cnt)
  );

  beat_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_xfer   = 0;
  int    exp_frames = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every accepted beat is popped and compared; stalled beats must hold.
  initial begin
    beat_t         exp;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [1:0]    prev_ch;
    logic          prev_last;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_ch    = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !bus.out_valid) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          n_checks++;
          if (bus.out_data !== prev_data || bus.out_ch !== prev_ch || bus.out_last !== prev_last) begin
            n_fail++;
            $display("FAIL hold: got data=%h ch=%0d last=%b, required data=%h ch=%0d last=%b",
                     bus.out_data, bus.out_ch, bus.out_last, prev_data, prev_ch, prev_last);
          end
        end
        if (bus.out_ready) begin
          n_xfer++;
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat: got data=%h ch=%0d, required no beat", bus.out_data, bus.out_ch);
          end else begin
            exp = sb.pop_front();
            if (bus.out_data !== exp.data || bus.out_ch !== exp.ch || bus.out_last !== exp.last) begin
              n_fail++;
              $display("FAIL beat: got data=%h ch=%0d last=%b, required data=%h ch=%0d last=%b",
                       bus.out_data, bus.out_ch, bus.out_last, exp.data, exp.ch, exp.last);
            end
          end
        end
        prev_stall = !bus.out_ready;
        prev_data  = bus.out_data;
        prev_ch    = bus.out_ch;
        prev_last  = bus.out_last;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [NCH*DW-1:0] d);
    beat_t b;
    for (int k = 0; k < NCH; k++) begin
      b.data = d[k*DW +: DW];
      b.ch   = 2'(k);
      b.last = (k == NCH - 1);
      sb.push_back(b);
    end
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d beats left, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; ce_pcm = 1'b0; ch_data = '0; clr_ovr = 1'b0; bus.out_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL rst_data: got %h, required 0", bus.out_data); end
    n_checks++; if (bus.out_ch !== '0) begin n_fail++; $display("FAIL rst_ch: got %0d, required 0", bus.out_ch); end
    n_checks++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %b, required 0", bus.out_last); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b, required 0", overrun); end
    n_checks++; if (frame_cnt !== '0) begin n_fail++; $display("FAIL rst_frame_cnt: got %0d, required 0", frame_cnt); end
    tick();
    rst = 1'b0;
    exp_frames = 0;
  endtask

  task automatic test_basic();
    int   vcnt;
    logic first;
    tick();
    en = 1'b1; bus.out_ready = 1'b1;
    ch_data = 64'h4444_3333_2222_1111;
    push_frame(ch_data);
    ce_pcm = 1'b1;
    tick();
    ce_pcm = 1'b0;
    vcnt = 0; first = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) first = bus.out_valid;
      if (bus.out_valid) vcnt++;
    end
    exp_frames++;
    n_checks++; if (first !== 1'b1) begin n_fail++; $display("FAIL basic_latency: valid=%b one cycle after ce_pcm, required 1", first); end
    n_checks++; if (vcnt != NCH) begin n_fail++; $display("FAIL basic_valid_len: got %0d cycles, required %0d", vcnt, NCH); end
    n_checks++; if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL basic_frame_cnt: got %0d, required %0d", frame_cnt, exp_frames); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL basic_overrun: got %b, required 0", overrun); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b, required 0", busy); end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL basic_beats: %0d beats left, required 0", sb.size()); end
  endtask

  task automatic test_ready_toggle();
    int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    int x0;
    tick();
    ch_data = 64'hDDDD_CCCC_BBBB_AAAA;
    push_frame(ch_data);
    ce_pcm = 1'b1;
    tick();
    ce_pcm = 1'b0;
    ch_data = 64'hDEAD_BEEF_0BAD_F00D;
    x0 = n_xfer;
    for (int i = 0; i < 7; i++) begin
      bus.out_ready = pat[i][0];
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    exp_frames++;
    n_checks++; if (n_xfer - x0 != NCH) begin n_fail++; $display("FAIL toggle_xfers: got %0d, required %0d", n_xfer - x0, NCH); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL toggle_idle: valid=%b, required 0", bus.out_valid); end
    n_checks++; if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL toggle_frame_cnt: got %0d, required %0d", frame_cnt, exp_frames); end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL toggle_beats: %0d beats left, required 0", sb.size()); end
  endtask

  task automatic test_overrun();
    logic bad;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; exp_frames = 0;
    bus.out_ready = 1'b0;
    ch_data = 64'h0004_0003_0002_0001;
    push_frame(ch_data);
    ce_pcm = 1'b1;
    tick();
    ce_pcm = 1'b0;
    bad = 1'b0;
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      if (overrun) bad = 1'b1;
      tick();
    end
    ce_pcm = 1'b1;
    ch_data = 64'h9999_8888_7777_6666;
    tick();
    ce_pcm = 1'b0;
    @(negedge clk);
    n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL ovr_early: overrun rose before second ce_pcm, required 0"); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b, required 1", overrun); end
    n_checks++; if (frame_cnt !== '0) begin n_fail++; $display("FAIL ovr_frame_cnt: got %0d, required 0", frame_cnt); end
    n_checks++; if (bus.out_data !== 16'h0001 || bus.out_ch !== 2'd0) begin
      n_fail++; $display("FAIL ovr_snapshot: got data=%h ch=%0d, required data=0001 ch=0", bus.out_data, bus.out_ch);
    end
    tick();
    ce_pcm = 1'b1; clr_ovr = 1'b1;
    tick();
    ce_pcm = 1'b0; clr_ovr = 1'b0;
    @(negedge clk);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins: got %b, required 1", overrun); end
    tick();
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    @(negedge clk);
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b, required 0", overrun); end
    tick();
    bus.out_ready = 1'b1;
    wait_empty("ovr");
    @(negedge clk);
    exp_frames++;
    n_checks++; if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL ovr_drain_cnt: got %0d, required %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_back_to_back();
    int gaps;
    logic [NCH*DW-1:0] d;
    tick();
    bus.out_ready = 1'b1;
    gaps = 0;
    for (int c = 0; c <= 20; c++) begin
      if (c % 4 == 0 && c <= 12) begin
        d = {$urandom, $urandom};
        push_frame(d);
        ch_data = d;
        ce_pcm = 1'b1;
      end else begin
        ce_pcm = 1'b0;
      end
      @(negedge clk);
      if (c >= 1 && c <= 16 && !bus.out_valid) gaps++;
      if (c == 5 || c == 9 || c == 13 || c == 17) begin
        n_checks++;
        if (frame_cnt !== 16'(exp_frames + (c - 1) / 4)) begin
          n_fail++; $display("FAIL b2b_frame_cnt: cycle %0d got %0d, required %0d", c, frame_cnt, exp_frames + (c - 1) / 4);
        end
      end
      if (c == 17) begin
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: valid=%b, required 0", bus.out_valid); end
      end
      tick();
    end
    ce_pcm = 1'b0;
    exp_frames += 4;
    n_checks++; if (gaps != 0) begin n_fail++; $display("FAIL b2b_gaps: got %0d gaps, required 0", gaps); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b, required 0", overrun); end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_beats: %0d beats left, required 0", sb.size()); end
  endtask

  task automatic test_en_off_reset();
    logic bad;
    tick();
    en = 1'b0; bus.out_ready = 1'b1; bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ce_pcm = (i % 2 == 0);
      @(negedge clk);
      if (bus.out_valid || busy) bad = 1'b1;
      tick();
    end
    ce_pcm = 1'b0;
    @(negedge clk);
    n_checks++; if (bad !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL en_off: valid seen with en=0, required none"); end
    tick();
    en = 1'b1;
    ch_data = 64'h5555_6666_7777_8888;
    push_frame(ch_data);
    ce_pcm = 1'b1;
    tick();
    ce_pcm = 1'b0;
    tick();
    rst = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.out_ch !== 2'd1 || bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_beat2: got ch=%0d valid=%b, required ch=1 valid=1", bus.out_ch, bus.out_valid);
    end
    tick();
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_ch !== '0 || bus.out_last !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_bus: got valid=%b data=%h ch=%0d last=%b, required all 0",
                         bus.out_valid, bus.out_data, bus.out_ch, bus.out_last);
    end
    n_checks++; if (busy !== 1'b0 || overrun !== 1'b0 || frame_cnt !== '0) begin
      n_fail++; $display("FAIL rst_mid_status: got busy=%b overrun=%b frame_cnt=%0d, required 0 0 0", busy, overrun, frame_cnt);
    end
    sb.delete();
    exp_frames = 0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    tick();
    en = 1'b1; bus.out_ready = 1'b1;
    force dut.frame_cnt = 16'hFFFF;
    tick();
    release dut.frame_cnt;
    @(negedge clk);
    n_checks++; if (frame_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h, required ffff", frame_cnt); end
    tick();
    ch_data = 64'h0123_4567_89AB_CDEF;
    push_frame(ch_data);
    ce_pcm = 1'b1;
    tick();
    ce_pcm = 1'b0;
    wait_empty("wrap");
    @(negedge clk);
    n_checks++; if (frame_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap: got %h, required 0000", frame_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrap_busy: got %b, required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_toggle();
    test_overrun();
    test_back_to_back();
    test_en_off_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pcm_frame_sched.md
Name: pcm_frame_sched

Overview:
- Schedules transfer of multi-microphone PCM samples onto one shared downstream sample bus.
- On each PCM-rate enable pulse (ce_pcm, one clk cycle wide, from the PCM prescaler), snapshots all channel outputs of the decimation filters.
- Serialises the snapshot channel by channel, 0 to NCH-1, over a valid/ready handshake.
- Tracks frames and flags overruns when the consumer cannot drain a frame within one PCM period.

Parameters:
- NCH, 4, number of microphone channels (2..16).
- DW, 16, PCM sample width in bits.
- FCW, 16, frame counter width.

Ports:
- clk  in  1  system clock (24 MHz domain).
- rst  in  1  synchronous active-high reset.
- en  in  1  capture enable; sampled only at frame start.
- ce_pcm  in  1  PCM-rate enable pulse, one clk cycle wide.
- ch_data  in  NCH*DW  channel samples; channel k occupies bits [k*DW+DW-1 : k*DW].
- clr_ovr  in  1  clears the overrun flag.
- out_data  out  DW  current sample.
- out_ch  out  clog2(NCH)  channel index of out_data.
- out_last  out  1  high while out_ch == NCH-1.
- out_valid  out  1  sample valid.
- out_ready  in  1  downstream accept.
- busy  out  1  frame in progress (state SEND).
- overrun  out  1  sticky overrun flag.
- frame_cnt  out  FCW  count of completed frames.

Behaviour:
- All outputs are registered.
- Reset values: out_data=0, out_ch=0, out_last=0, out_valid=0, busy=0, overrun=0, frame_cnt=0. State is IDLE, snapshot register is 0.
- Reset applies in any state. A frame in progress is discarded, with no partial completion and no frame_cnt increment.
- Two states: IDLE and SEND.
- IDLE, entering SEND:
  - Condition: ce_pcm=1 and en=1.
  - Latch the whole ch_data vector into the snapshot.
  - Next cycle: busy=1, out_valid=1, out_ch=0, out_data=snapshot[0].
  - Latency from ce_pcm to first out_valid is exactly 1 cycle.
- IDLE, otherwise: ce_pcm is ignored when en=0, and overrun is not set.
- SEND, handshake:
  - A transfer occurs on a cycle with out_valid=1 and out_ready=1.
  - If out_ch < NCH-1: out_ch increments and out_data takes the next snapshot word on the following cycle. out_valid stays high.
- SEND, holding: while out_ready=0, out_data, out_ch and out_last are held stable. out_valid never drops mid-frame.
- SEND, final transfer (out_ch == NCH-1):
  - frame_cnt increments, wrapping modulo 2^FCW.
  - If no new frame starts on the same cycle: return to IDLE with out_valid=0 and busy=0 on the next cycle.
- ce_pcm during SEND, not on the final-transfer cycle:
  - overrun is set to 1.
  - The new samples are dropped. The current snapshot is unaffected and the frame completes normally.
- ce_pcm on the final-transfer cycle, with en=1:
  - Not an overrun.
  - The new snapshot is latched and SEND continues with out_ch=0 next cycle. out_valid stays high (back-to-back frames).
- en deasserted mid-frame: the current frame completes. No new frame starts while en=0.
- clr_ovr=1 clears overrun next cycle. If a new overrun condition occurs on the same cycle, the set wins and overrun stays 1.
- out_ch and out_last are combinationally consistent with the registered index.
- In IDLE, out_data and out_ch hold their last values, which are don't-care for consumers.
- Snapshot storage is NCH*DW flops. The index counter is clog2(NCH) bits and never exceeds NCH-1.

Test Plan:
- Reset, then en=1, NCH=4, ch_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111}, out_ready=1, single ce_pcm pulse:
  - out_valid high for exactly 4 cycles starting 1 cycle after ce_pcm.
  - out_data sequence 1111, 2222, 3333, 4444; out_ch 0..3; out_last only on the 4th beat.
  - frame_cnt=1, overrun=0.
- Same frame with out_ready toggling 1,0,0,1,0,1,1:
  - Each sample is held stable while ready=0.
  - Exactly 4 transfers; data order is unchanged.
  - Changing ch_data after ce_pcm does not alter output (snapshot check).
- out_ready=0 permanently, ce_pcm at cycles 0 and 20:
  - overrun=1 after cycle 21; stays on 0 throughout; frame_cnt=0.
  - Pulse clr_ovr: overrun=0 the next cycle.
- out_ready=1, ce_pcm every 4 cycles, aligned so each pulse coincides with the final transfer:
  - Continuous out_valid with no gaps.
  - overrun stays 0; frame_cnt increments every 4 cycles.
- en=0 with ce_pcm pulses: no out_valid. Then assert rst while in SEND on the 2nd beat: all outputs return to reset values next cycle, frame_cnt=0.
- Preload frame_cnt to 16'hFFFF via repeated frames, or force it, then complete one more frame: frame_cnt=0 (wrap).
